// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath bundle for the iterative AES-128 round sequencer.
//
// Signals:
//   in_valid/in_ready/in_block/key0  upstream block source handshake
//   abort                            synchronous cancel of the current block
//   load_sel                         state mux select (1 = load, 0 = feedback)
//   rnd_state/rnd_out                state to, and result from, the round datapath
//   rnd_idx/rnd_last                 round number and final-round flag
//   out_valid/out_ready/out_block    ciphertext handshake
//
// Modports:
//   slave   the round controller
//   master  everything around it (block source, round datapath, sink)
interface aes_round_ctrl_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_block;
  logic [DATA_W-1:0] key0;
  logic              abort;
  logic              load_sel;
  logic [DATA_W-1:0] rnd_state;
  logic [DATA_W-1:0] rnd_out;
  logic [CNT_W-1:0]  rnd_idx;
  logic              rnd_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_block;

  modport slave (
    input  in_valid, in_block, key0, abort, rnd_out, out_ready,
    output in_ready, load_sel, rnd_state, rnd_idx, rnd_last, out_valid, out_block
  );

  modport master (
    output in_valid, in_block, key0, abort, rnd_out, out_ready,
    input  in_ready, load_sel, rnd_state, rnd_idx, rnd_last, out_valid, out_block
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer.
//
// Owns the cipher state register and the load/feedback mux in front of it. A block is
// accepted as in_block ^ key0 (initial AddRoundKey), then the external combinational round
// datapath is applied NR times, one round per cycle, and the result is offered on
// out_block with a valid/ready handshake. Back-to-back blocks are accepted on the same
// edge the previous ciphertext is taken.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   aes_round_ctrl_if slave modport (upstream, round datapath, downstream)
module aes_round_ctrl #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NR     = 10,
  parameter int unsigned CNT_W  = 4
) (
  input logic           clk,
  input logic           rst,
  aes_round_ctrl_if.slave bus
);

  if ((2 ** CNT_W) <= NR) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold NR");
  end

  localparam logic [CNT_W-1:0] NrCnt  = CNT_W'(NR);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            st_q;
  logic [CNT_W-1:0]  idx_q;
  logic [DATA_W-1:0] state_q;
  logic              accept;

  // rst gating keeps the upstream from seeing a ready while the controller is held.
  assign bus.in_ready = ~rst & ~bus.abort &
                        ((st_q == StIdle) | ((st_q == StDone) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.load_sel = accept;

  assign bus.rnd_state = state_q;
  assign bus.rnd_idx   = idx_q;
  assign bus.rnd_last  = (st_q == StRun) & (idx_q == NrCnt);
  assign bus.out_valid = (st_q == StDone);
  assign bus.out_block = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      idx_q   <= '0;
      state_q <= '0;
    end else if (bus.abort) begin
      // State register deliberately holds; only the sequencing is cancelled.
      st_q  <= StIdle;
      idx_q <= '0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (accept) begin
            state_q <= bus.in_block ^ bus.key0;
            st_q    <= StRun;
            idx_q   <= OneCnt;
          end
        end
        StRun: begin
          state_q <= bus.rnd_out;
          if (idx_q == NrCnt) begin
            st_q  <= StDone;
            idx_q <= '0;
          end else begin
            idx_q <= idx_q + OneCnt;
          end
        end
        StDone: begin
          if (accept) begin
            state_q <= bus.in_block ^ bus.key0;
            st_q    <= StRun;
            idx_q   <= OneCnt;
          end else if (bus.out_ready) begin
            st_q <= StIdle;
          end
        end
        default: begin
          st_q  <= StIdle;
          idx_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: table-driven blocks plus directed sequences for
// reset, backpressure, abort and back-to-back operation. The round datapath is modelled
// here either as a counter (rnd_state + 1) or as a real AES-128 round.
module tb_aes_round_ctrl;

  logic clk;
  logic rst;

  aes_round_ctrl_if #(.DATA_W(128), .CNT_W(4)) bus ();

  aes_round_ctrl #(.DATA_W(128), .NR(10), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  logic         aes_mode = 1'b0;
  logic [7:0]   sbox_t [256];
  logic [127:0] rk [11];

  typedef struct {
    logic         aes;
    logic [127:0] blk;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  // ---------------------------------------------------------------- AES reference model
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from the GF(2^8) inverse plus affine transform.
  initial begin
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      if (i != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(i));
      end
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_rnd(input logic [127:0] st, input logic [3:0] idx,
                                           input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[st[127 - 8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = t[i];
    return o ^ ((idx <= 4'd10) ? rk[idx] : 128'h0);
  endfunction

  // Round datapath: result settles well before the next rising edge.
  initial bus.rnd_out = '0;
  always @(negedge clk) begin
    if (aes_mode) bus.rnd_out = aes_rnd(bus.rnd_state, bus.rnd_idx, bus.rnd_last);
    else          bus.rnd_out = bus.rnd_state + 128'd1;
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n;
    n = 0;
    while (bus.rnd_idx != target && n < 30) begin
      tick();
      n++;
    end
    chk("wait_idx_reached", 128'(bus.rnd_idx), 128'(target));
  endtask

  // Called right after the accept edge; counts edges until out_valid.
  task automatic wait_done(output int lat, output int nlast, output logic last_ok);
    lat     = -1;
    nlast   = 0;
    last_ok = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      if (bus.rnd_last) begin
        nlast++;
        if (bus.rnd_idx != 4'd10) last_ok = 1'b0;
      end
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   lat;
    int   nlast;
    logic last_ok;
    aes_mode = v.aes;
    if (v.aes) expand_key(v.key);
    bus.in_block  = v.blk;
    bus.key0      = v.key;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    #1;
    chk({name, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    chk({name, "_load_sel"}, 128'(bus.load_sel), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat, nlast, last_ok);
    chk({name, "_latency"}, 128'(lat), 128'd10);
    chk({name, "_rnd_last_count"}, 128'(nlast), 128'd1);
    chk({name, "_rnd_last_idx"}, 128'(last_ok), 128'd1);
    chk({name, "_out_block"}, bus.out_block, v.exp);
    bus.out_ready = 1'b1;
    tick();
    chk({name, "_drained"}, 128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- test
  initial begin
    int   lat;
    int   nlast;
    logic last_ok;
    logic seen;
    int   got;
    int   sent;
    int   last_cyc;
    logic will_accept;
    logic [127:0] expv [4];

    vecs[0] = '{1'b0, 128'h0F, 128'h05, 128'h14};
    vecs[1] = '{1'b0, 128'h0, 128'h0, 128'h0A};
    vecs[2] = '{1'b0, {128{1'b1}}, 128'h0, 128'h09};
    vecs[3] = '{1'b0, 128'hAA00, 128'h00FF, 128'hAB09};
    vecs[4] = '{1'b1, 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.key0      = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_rnd_idx", 128'(bus.rnd_idx), 128'd0);
    chk("rst_rnd_last", 128'(bus.rnd_last), 128'd0);
    chk("rst_state", bus.rnd_state, 128'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 128'(bus.in_ready), 128'd1);
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Async reset mid-RUN at round 5.
    aes_mode     = 1'b0;
    bus.in_block = 128'h0F;
    bus.key0     = 128'h05;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_idx(4'd5);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_rnd_idx", 128'(bus.rnd_idx), 128'd0);
    chk("arst_state", bus.rnd_state, 128'd0);
    chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("arst_rnd_last", 128'(bus.rnd_last), 128'd0);
    chk("arst_in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    tick();
    chk("arst_held_in_ready", 128'(bus.in_ready), 128'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_release_in_ready", 128'(bus.in_ready), 128'd1);
    tick();

    // Backpressure then same-edge handoff.
    bus.in_block = 128'h0F;
    bus.key0     = 128'h05;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat, nlast, last_ok);
    chk("bp_latency", 128'(lat), 128'd10);
    bus.in_block  = 128'h20;
    bus.key0      = 128'h01;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_out_block", bus.out_block, 128'h14);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("handoff_in_ready", 128'(bus.in_ready), 128'd1);
    chk("handoff_load_sel", 128'(bus.load_sel), 128'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    wait_done(lat, nlast, last_ok);
    chk("handoff_latency", 128'(lat), 128'd10);
    chk("handoff_out_block", bus.out_block, 128'h2B);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Abort at round 3.
    bus.in_block = 128'h0F;
    bus.key0     = 128'h05;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_idx(4'd3);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    chk("abort_in_ready", 128'(bus.in_ready), 128'd0);
    chk("abort_load_sel", 128'(bus.load_sel), 128'd0);
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("abort_rnd_idx", 128'(bus.rnd_idx), 128'd0);
    chk("abort_state_held", bus.rnd_state, 128'h0C);
    chk("abort_idle_in_ready", 128'(bus.in_ready), 128'd1);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_out_valid", 128'(seen), 128'd0);
    run_vec(vecs[0], "post_abort");

    // Back-to-back, out_ready tied high.
    for (int k = 0; k < 4; k++) expv[k] = ((128'(k + 1) << 8) ^ 128'(k + 1)) + 128'd10;
    bus.out_ready = 1'b1;
    bus.in_block  = 128'(1) << 8;
    bus.key0      = 128'(1);
    bus.in_valid  = 1'b1;
    #1;
    got      = 0;
    sent     = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      will_accept = bus.in_valid & bus.in_ready;
      if (bus.out_valid) begin
        chk($sformatf("b2b_out_block%0d", got), bus.out_block, expv[got]);
        if (got > 0) chk("b2b_spacing", 128'(cyc - last_cyc), 128'd11);
        last_cyc = cyc;
        got++;
      end
      if (got == 4) break;
      tick();
      if (will_accept) begin
        sent++;
        if (sent < 4) begin
          bus.in_block = 128'(sent + 1) << 8;
          bus.key0     = 128'(sent + 1);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      #1;
    end
    chk("b2b_blocks_out", 128'(got), 128'd4);
    tick();
    chk("b2b_idle", 128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule
